// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared encodings for the ID-stage branch resolution logic: branch op codes,
// sequencer states and small decode helpers used by decoder, comparator and sequencer.
package branch_resolve_ctrl_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLEZ = 3'b011;
    localparam logic [2:0] BR_BGTZ = 3'b100;
    localparam logic [2:0] BR_BLTZ = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WAIT     = 2'b01,
        ST_REDIRECT = 2'b10
    } br_state_e;

    // True for the five real conditional branch encodings.
    function automatic logic is_branch_op(input logic [2:0] op);
        logic res;
        case (op)
            BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ, BR_BLTZ: res = 1'b1;
            default:                                   res = 1'b0;
        endcase
        return res;
    endfunction

    // 11x encodings are reserved and flagged as illegal.
    function automatic logic is_illegal_op(input logic [2:0] op);
        return (op[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_br_event_counter.sv
// Wrap-around event counter with asynchronous active-low clear and increment enable.
module br_event_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_r;

    // Count register; natural overflow gives the wrap from all-ones to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch sequencer: stalls on operand hazards, resolves the branch through
// the external comparator and issues a one-cycle registered PC redirect plus IF/ID flush.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_br_valid,
    input  logic [2:0]       i_branch,
    input  logic             i_opnd_hazard,
    input  logic             i_taken,
    input  logic [PC_W-1:0]  i_target,
    output logic [2:0]       o_cmp_op,
    output logic             o_stall,
    output logic             o_pc_sel,
    output logic             o_flush,
    output logic [PC_W-1:0]  o_target,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_taken_cnt
);

    br_state_e         state_r;
    br_state_e         state_nxt_s;
    logic              present_s;
    logic              illegal_s;
    logic              resolve_s;
    logic              take_s;
    logic              stall_s;
    logic [2:0]        cmp_op_s;
    logic              pc_sel_r;
    logic              flush_r;
    logic              illegal_r;
    logic [PC_W-1:0]   target_r;

    // Decode of the ID-stage instruction; everything is masked during REDIRECT.
    always_comb begin
        present_s = 1'b0;
        illegal_s = 1'b0;
        if (state_r != ST_REDIRECT) begin
            present_s = i_br_valid && is_branch_op(i_branch);
            illegal_s = i_br_valid && is_illegal_op(i_branch);
        end else begin
            present_s = 1'b0;
            illegal_s = 1'b0;
        end
        resolve_s = present_s && !i_opnd_hazard;
        take_s    = resolve_s && i_taken;
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE, ST_WAIT: begin
                if (present_s && i_opnd_hazard) begin
                    state_nxt_s = ST_WAIT;
                end else if (take_s) begin
                    state_nxt_s = ST_REDIRECT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REDIRECT: state_nxt_s = ST_IDLE;
            default:     state_nxt_s = ST_IDLE;
        endcase
    end

    // Combinational outputs; gated by reset so they collapse with the registered pulses.
    always_comb begin
        stall_s  = 1'b0;
        cmp_op_s = BR_NONE;
        if (i_rst_n && present_s) begin
            stall_s  = i_opnd_hazard;
            cmp_op_s = i_branch;
        end else begin
            stall_s  = 1'b0;
            cmp_op_s = BR_NONE;
        end
    end

    // Registered redirect, flush and illegal pulses plus the captured target.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_sel_r  <= 1'b0;
            flush_r   <= 1'b0;
            illegal_r <= 1'b0;
            target_r  <= {PC_W{1'b0}};
        end else begin
            pc_sel_r  <= take_s;
            flush_r   <= take_s;
            illegal_r <= illegal_s;
            if (take_s) begin
                target_r <= i_target;
            end else begin
                target_r <= target_r;
            end
        end
    end

    br_event_counter #(.CNT_W(CNT_W)) u_br_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (resolve_s),
        .count (o_br_cnt)
    );

    br_event_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (take_s),
        .count (o_taken_cnt)
    );

    assign o_cmp_op  = cmp_op_s;
    assign o_stall   = stall_s;
    assign o_pc_sel  = pc_sel_r;
    assign o_flush   = flush_r;
    assign o_target  = target_r;
    assign o_illegal = illegal_r;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl; a second narrow-counter instance exercises wrap-around.
module tb_branch_resolve_ctrl;

    logic        clk;
    logic        rst_n;
    logic        br_valid;
    logic [2:0]  branch;
    logic        opnd_hazard;
    logic        taken;
    logic [31:0] target;
    logic [2:0]  cmp_op;
    logic        stall;
    logic        pc_sel;
    logic        flush;
    logic [31:0] tgt_out;
    logic        illegal;
    logic [15:0] br_cnt;
    logic [15:0] taken_cnt;

    logic        w_valid;
    logic [2:0]  w_branch;
    logic        w_taken;
    logic [31:0] w_target;
    logic [2:0]  w_cmp_op;
    logic        w_stall;
    logic        w_pc_sel;
    logic        w_flush;
    logic [31:0] w_tgt_out;
    logic        w_illegal;
    logic [3:0]  w_br_cnt;
    logic [3:0]  w_taken_cnt;

    int checks;
    int failures;

    branch_resolve_ctrl #(.PC_W(32), .CNT_W(16)) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_br_valid    (br_valid),
        .i_branch      (branch),
        .i_opnd_hazard (opnd_hazard),
        .i_taken       (taken),
        .i_target      (target),
        .o_cmp_op      (cmp_op),
        .o_stall       (stall),
        .o_pc_sel      (pc_sel),
        .o_flush       (flush),
        .o_target      (tgt_out),
        .o_illegal     (illegal),
        .o_br_cnt      (br_cnt),
        .o_taken_cnt   (taken_cnt)
    );

    branch_resolve_ctrl #(.PC_W(32), .CNT_W(4)) u_dut_w (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_br_valid    (w_valid),
        .i_branch      (w_branch),
        .i_opnd_hazard (1'b0),
        .i_taken       (w_taken),
        .i_target      (w_target),
        .o_cmp_op      (w_cmp_op),
        .o_stall       (w_stall),
        .o_pc_sel      (w_pc_sel),
        .o_flush       (w_flush),
        .o_target      (w_tgt_out),
        .o_illegal     (w_illegal),
        .o_br_cnt      (w_br_cnt),
        .o_taken_cnt   (w_taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic hz,
                         input logic tk, input logic [31:0] tg);
        br_valid = v; branch = op; opnd_hazard = hz; taken = tk; target = tg;
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        br_valid = 1'b0; branch = 3'b000; opnd_hazard = 1'b0; taken = 1'b0; target = 32'h0;
        w_valid = 1'b0; w_branch = 3'b000; w_taken = 1'b0; w_target = 32'h0;
        repeat (3) tick();
        chk("rst_pc_sel", {31'd0, pc_sel}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_target", tgt_out, 32'd0);
        chk("rst_br_cnt", {16'd0, br_cnt}, 32'd0);
        chk("rst_taken_cnt", {16'd0, taken_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: taken beq, no hazard
        drive(1'b1, 3'b001, 1'b0, 1'b1, 32'h0040_0100);
        chk("t1_stall_R", {31'd0, stall}, 32'd0);
        chk("t1_cmp_op_R", {29'd0, cmp_op}, 32'd1);
        tick();
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
        chk("t1_pc_sel_R1", {31'd0, pc_sel}, 32'd1);
        chk("t1_flush_R1", {31'd0, flush}, 32'd1);
        chk("t1_target_R1", tgt_out, 32'h0040_0100);
        chk("t1_stall_R1", {31'd0, stall}, 32'd0);
        chk("t1_br_cnt", {16'd0, br_cnt}, 32'd1);
        chk("t1_taken_cnt", {16'd0, taken_cnt}, 32'd1);
        tick();
        chk("t1_pc_sel_R2", {31'd0, pc_sel}, 32'd0);
        chk("t1_flush_R2", {31'd0, flush}, 32'd0);

        // 2: bne held by hazard for two cycles, then not taken
        drive(1'b1, 3'b010, 1'b1, 1'b0, 32'h0000_2000);
        chk("t2_stall_c0", {31'd0, stall}, 32'd1);
        tick();
        chk("t2_stall_c1", {31'd0, stall}, 32'd1);
        chk("t2_cnt_wait", {16'd0, br_cnt}, 32'd1);
        tick();
        drive(1'b1, 3'b010, 1'b0, 1'b0, 32'h0000_2000);
        chk("t2_stall_res", {31'd0, stall}, 32'd0);
        chk("t2_cmp_op", {29'd0, cmp_op}, 32'd2);
        tick();
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
        chk("t2_pc_sel", {31'd0, pc_sel}, 32'd0);
        chk("t2_br_cnt", {16'd0, br_cnt}, 32'd2);
        chk("t2_taken_cnt", {16'd0, taken_cnt}, 32'd1);

        // 3: three back-to-back not-taken blez
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'b011, 1'b0, 1'b0, 32'h0);
            chk("t3_stall", {31'd0, stall}, 32'd0);
            tick();
        end
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
        chk("t3_br_cnt", {16'd0, br_cnt}, 32'd5);
        chk("t3_pc_sel", {31'd0, pc_sel}, 32'd0);

        // 4: taken bgtz, then bltz in ID during REDIRECT is ignored
        drive(1'b1, 3'b100, 1'b0, 1'b1, 32'h0000_1234);
        chk("t4_cmp_bgtz", {29'd0, cmp_op}, 32'd4);
        tick();
        drive(1'b1, 3'b101, 1'b1, 1'b1, 32'h0000_5678);
        chk("t4_cmp_redir", {29'd0, cmp_op}, 32'd0);
        chk("t4_stall_redir", {31'd0, stall}, 32'd0);
        chk("t4_pc_sel_redir", {31'd0, pc_sel}, 32'd1);
        tick();
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
        chk("t4_pc_sel_after", {31'd0, pc_sel}, 32'd0);
        chk("t4_br_cnt", {16'd0, br_cnt}, 32'd6);
        chk("t4_taken_cnt", {16'd0, taken_cnt}, 32'd2);
        chk("t4_target", tgt_out, 32'h0000_1234);

        // 5a: illegal op 111
        drive(1'b1, 3'b111, 1'b1, 1'b1, 32'h0000_9999);
        chk("t5_stall_ill", {31'd0, stall}, 32'd0);
        chk("t5_cmp_ill", {29'd0, cmp_op}, 32'd0);
        tick();
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
        chk("t5_illegal_pulse", {31'd0, illegal}, 32'd1);
        chk("t5_br_cnt", {16'd0, br_cnt}, 32'd6);
        chk("t5_pc_sel", {31'd0, pc_sel}, 32'd0);
        tick();
        chk("t5_illegal_drop", {31'd0, illegal}, 32'd0);

        // 5b: narrow counters preset to all-ones then wrapped by one taken branch
        for (int i = 0; i < 15; i++) begin
            w_valid = 1'b1; w_branch = 3'b001; w_taken = 1'b1; w_target = 32'h0000_0F00;
            tick();
            w_valid = 1'b0; w_branch = 3'b000; w_taken = 1'b0;
            tick();
        end
        chk("t5_w_br_full", {28'd0, w_br_cnt}, 32'hF);
        chk("t5_w_taken_full", {28'd0, w_taken_cnt}, 32'hF);
        w_valid = 1'b1; w_branch = 3'b101; w_taken = 1'b1; w_target = 32'h0000_0ABC;
        #1;
        chk("t5_w_cmp_op", {29'd0, w_cmp_op}, 32'd5);
        tick();
        w_valid = 1'b0; w_branch = 3'b000; w_taken = 1'b0;
        chk("t5_w_br_wrap", {28'd0, w_br_cnt}, 32'h0);
        chk("t5_w_taken_wrap", {28'd0, w_taken_cnt}, 32'h0);
        chk("t5_w_pc_sel", {31'd0, w_pc_sel}, 32'd1);
        chk("t5_w_flush", {31'd0, w_flush}, 32'd1);
        chk("t5_w_target", w_tgt_out, 32'h0000_0ABC);
        chk("t5_w_stall", {31'd0, w_stall}, 32'd0);
        chk("t5_w_illegal", {31'd0, w_illegal}, 32'd0);
        tick();

        // 6a: reset asserted during WAIT
        drive(1'b1, 3'b010, 1'b1, 1'b0, 32'h0);
        tick();
        chk("t6_stall_wait", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_stall_rst", {31'd0, stall}, 32'd0);
        chk("t6_cmp_rst", {29'd0, cmp_op}, 32'd0);
        chk("t6_br_cnt_rst", {16'd0, br_cnt}, 32'd0);
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        drive(1'b1, 3'b001, 1'b0, 1'b0, 32'h0);
        chk("t6_stall_idle", {31'd0, stall}, 32'd0);
        tick();
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
        chk("t6_br_cnt_idle", {16'd0, br_cnt}, 32'd1);

        // 6b: reset asserted during REDIRECT
        drive(1'b1, 3'b001, 1'b0, 1'b1, 32'h0040_0200);
        tick();
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
        chk("t6_pc_sel_redir", {31'd0, pc_sel}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_pc_sel_rst", {31'd0, pc_sel}, 32'd0);
        chk("t6_flush_rst", {31'd0, flush}, 32'd0);
        chk("t6_target_rst", tgt_out, 32'd0);
        chk("t6_taken_cnt_rst", {16'd0, taken_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_pc_sel_rel", {31'd0, pc_sel}, 32'd0);
        drive(1'b1, 3'b010, 1'b1, 1'b0, 32'h0);
        chk("t6_stall_rel", {31'd0, stall}, 32'd1);
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
